// File: rtl/seq_pkg.sv
// Shared types and helpers for the serializer and the sequence detector bench.
package seq_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int MAX_WIDTH = 32;

    // Reverses a full MAX_WIDTH word; callers take the top bits for narrower words.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = w[MAX_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_hold_reg.sv
// One-word holding register with a full flag; lets a second word wait behind the shifter.
module seq_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_take,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load wins over take; the two never coincide because loading requires an empty register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock on seq_out.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             seq_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic             r_word_done;
    logic             w_word_done_nxt;

    logic             w_accept;
    logic             w_hold_full;
    logic             w_hold_load;
    logic             w_hold_take;
    logic [WIDTH-1:0] w_hold_data;
    logic [WIDTH-1:0] w_word_rev;
    logic [WIDTH-1:0] w_word_ord;

    // The shifter always moves left, so LSB-first words are reversed once on entry.
    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign w_word_rev[g] = word_in[WIDTH-1-g];
    end

    assign w_word_ord = MSB_FIRST ? word_in : w_word_rev;
    assign w_accept   = word_valid && !w_hold_full;

    seq_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_hold_load),
        .i_take (w_hold_take),
        .i_data (w_word_ord),
        .o_full (w_hold_full),
        .o_data (w_hold_data)
    );

    // State, shifter, bit counter and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SER_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    // Next-state logic; on the last bit the held word takes priority over a new input word.
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_word_done_nxt = 1'b0;
        w_hold_load     = 1'b0;
        w_hold_take     = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt   = w_word_ord;
                    w_bit_cnt_nxt = CNT_LAST;
                    w_state_nxt   = SER_SHIFT;
                end else begin
                    w_state_nxt   = SER_IDLE;
                end
            end
            SER_SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                    w_hold_load   = w_accept;
                end else begin
                    w_word_done_nxt = 1'b1;
                    if (w_hold_full) begin
                        w_shreg_nxt   = w_hold_data;
                        w_bit_cnt_nxt = CNT_LAST;
                        w_hold_take   = 1'b1;
                    end else if (w_accept) begin
                        w_shreg_nxt   = w_word_ord;
                        w_bit_cnt_nxt = CNT_LAST;
                    end else begin
                        w_state_nxt   = SER_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = SER_IDLE;
            end
        endcase
    end

    assign word_ready = !w_hold_full;
    assign seq_out    = (r_state == SER_SHIFT) ? r_shreg[WIDTH-1] : IDLE_LEVEL;
    assign bit_valid  = (r_state == SER_SHIFT);
    assign word_done  = r_word_done;
    assign busy       = (r_state == SER_SHIFT) || w_hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized scoreboard bench: one MSB-first and one LSB-first serializer share stimulus.
module tb_seq_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] word_in;
    logic       word_valid;

    logic m_ready, m_seq, m_bv, m_done, m_busy;
    logic l_ready, l_seq, l_bv, l_done, l_busy;

    int  n_checks = 0;
    int  n_errs   = 0;
    bit  q_msb[$];
    bit  q_lsb[$];
    bit  done_pend = 1'b0;

    seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(m_ready), .seq_out(m_seq), .bit_valid(m_bv),
        .word_done(m_done), .busy(m_busy)
    );

    seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(l_ready), .seq_out(l_seq), .bit_valid(l_bv),
        .word_done(l_done), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model is just the list of bits still owed, in wire order.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_seq_m", m_seq, 1'b0);   check("rst_seq_l", l_seq, 1'b0);
            check("rst_bv_m", m_bv, 1'b0);     check("rst_bv_l", l_bv, 1'b0);
            check("rst_rdy_m", m_ready, 1'b1); check("rst_rdy_l", l_ready, 1'b1);
            check("rst_busy_m", m_busy, 1'b0); check("rst_busy_l", l_busy, 1'b0);
            check("rst_done_m", m_done, 1'b0); check("rst_done_l", l_done, 1'b0);
            q_msb.delete();
            q_lsb.delete();
            done_pend = 1'b0;
        end else begin
            int n;
            n = q_msb.size();
            check("bit_valid_m", m_bv, n > 0);   check("bit_valid_l", l_bv, n > 0);
            check("busy_m", m_busy, n > 0);      check("busy_l", l_busy, n > 0);
            check("ready_m", m_ready, n <= 4);   check("ready_l", l_ready, n <= 4);
            check("done_m", m_done, done_pend);  check("done_l", l_done, done_pend);
            if (n > 0) begin
                check("seq_m", m_seq, q_msb.pop_front());
                check("seq_l", l_seq, q_lsb.pop_front());
                done_pend = (q_msb.size() % 4 == 0);
            end else begin
                check("idle_m", m_seq, 1'b0);
                check("idle_l", l_seq, 1'b0);
                done_pend = 1'b0;
            end
        end
    end

    // Offer one word after an idle gap; expected bits are queued as the accept edge is committed.
    task automatic send(input logic [3:0] w, input int gap);
        int tries;
        word_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        word_valid = 1'b1;
        word_in    = w;
        tries      = 0;
        forever begin
            @(negedge clk);
            #1;
            if (m_ready) begin
                for (int i = 3; i >= 0; i--) q_msb.push_back(w[i]);
                for (int i = 0; i <= 3; i++) q_lsb.push_back(w[i]);
                @(posedge clk);
                #1;
                word_valid = 1'b0;
                break;
            end
            tries++;
            if (tries > 50) begin
                n_checks++;
                n_errs++;
                $display("FAIL accept_timeout: word %b never accepted", w);
                word_valid = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        word_in    = 4'b0000;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        send(4'b1011, 1);
        send(4'b1011, 6);
        send(4'b0110, 0);
        send(4'b1100, 6);
        send(4'b0011, 0);
        send(4'b1010, 0);

        send(4'b1001, 14);
        send(4'b0110, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;

        send(4'b1101, 2);
        send(4'b0000, 6);
        send(4'b1111, 0);
        for (int k = 0; k < 40; k++) begin
            send(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
        end

        waited = 0;
        while (q_msb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (q_msb.size() != 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL drain_timeout: %0d bits still owed", q_msb.size());
        end
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
